// File: rtl/capture_pkg.sv
// Shared defaults and FSM encoding for the capture buffer.
package capture_pkg;
  localparam int CAP_DATA_W   = 33;
  localparam int CAP_ADDR_W   = 10;
  localparam int CAP_PRE_TRIG = 256;

  typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, READ} cap_state_t;
endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module capture_ram
  import capture_pkg::*;
#(
  parameter int DATA_W = CAP_DATA_W,
  parameter int ADDR_W = CAP_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Storage is never cleared; only the read register returns to zero.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset)   q <= '0;
    else if (re) q <= mem[raddr];
  end
endmodule

// File: rtl/capture_buffer.sv
// Pre/post-trigger capture into a circular RAM with ready/valid readout.
// Optional CAPTURE_TIMEOUT_EN forces a trigger after TIMEOUT_CYC idle WAIT cycles.
module capture_buffer
  import capture_pkg::*;
#(
  parameter int DATA_W      = CAP_DATA_W,
  parameter int ADDR_W      = CAP_ADDR_W,
`ifdef CAPTURE_TIMEOUT_EN
  parameter int TIMEOUT_CYC = 65535,
`endif
  parameter int PRE_TRIG    = CAP_PRE_TRIG
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              arm,
  input  logic [DATA_W-1:0] data,
  input  logic              trig,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr
`ifdef CAPTURE_TIMEOUT_EN
  ,
  output logic              timed_out
`endif
);
  localparam int DEPTH  = 2**ADDR_W;
  localparam int POST_N = DEPTH - PRE_TRIG - 1;
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'((POST_N > 0) ? POST_N - 1 : 0);
  localparam logic [ADDR_W-1:0] READ_LAST = ADDR_W'(DEPTH - 1);

  cap_state_t        state;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, cnt, raddr;
  logic              we, re, timeout_hit;

`ifdef CAPTURE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;
  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign we = (state == PRE) || (state == WAIT) || (state == POST);

  // RAM output is the readout register: hold the address while stalled,
  // fetch the next word on a transfer so back-to-back reads run every cycle.
  always_comb begin
    re    = 1'b0;
    raddr = rd_ptr;
    if (state == READ) begin
      if (!rd_valid) begin
        re = 1'b1;
      end else if (rd_ready && cnt != READ_LAST) begin
        re    = 1'b1;
        raddr = rd_ptr + 1'b1;
      end
    end
  end

  capture_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clock (clock),
    .reset (reset),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (data),
    .re    (re),
    .raddr (raddr),
    .q     (rd_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      trig_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_valid  <= 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
      to_cnt    <= '0;
      timed_out <= 1'b0;
`endif
    end else begin
      if (we) wr_ptr <= wr_ptr + 1'b1;
      unique case (state)
        IDLE: if (arm) begin
          state  <= PRE;
          wr_ptr <= '0;
          cnt    <= '0;
          busy   <= 1'b1;
`ifdef CAPTURE_TIMEOUT_EN
          timed_out <= 1'b0;
`endif
        end
        PRE: begin
          cnt <= cnt + 1'b1;
          if (cnt == PRE_LAST) begin
            cnt   <= '0;
            state <= WAIT;
`ifdef CAPTURE_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end
        end
        WAIT: begin
`ifdef CAPTURE_TIMEOUT_EN
          to_cnt <= to_cnt + 1'b1;
`endif
          if (trig || timeout_hit) begin
            trig_addr <= wr_ptr;
            rd_ptr    <= wr_ptr - ADDR_W'(PRE_TRIG);
            cnt       <= '0;
            state     <= (POST_N == 0) ? READ : POST;
            done      <= (POST_N == 0);
`ifdef CAPTURE_TIMEOUT_EN
            timed_out <= !trig;
`endif
          end
        end
        POST: begin
          cnt <= cnt + 1'b1;
          if (cnt == POST_LAST) begin
            cnt   <= '0;
            state <= READ;
            done  <= 1'b1;
          end
        end
        READ: begin
          if (!rd_valid) begin
            rd_valid <= 1'b1;
          end else if (rd_ready) begin
            if (cnt == READ_LAST) begin
              state    <= IDLE;
              rd_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b0;
            end else begin
              cnt    <= cnt + 1'b1;
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
